operand_issue_stage: RTL and testbench
======================================

Name: operand_issue_stage

Overview:
- Upstream neighbour of the 8-bit ALU. Holds the 8x8-bit architectural register file and decodes 12-bit instructions.
- Reads the rs/rt operands and presents them to the ALU through a registered valid/ready output stage.
- Accepts ALU results back on a writeback port.
- A per-register pending scoreboard stalls issue on read-after-write hazards.

Parameters:
- NUM_REGS, 8, number of architectural registers; addressed by 3-bit fields; r0 reads as zero.
- DATA_W, 8, operand/result width; must match the ALU.

Ports:
- clk_i  input  1  clock, rising edge
- rst_n_i  input  1  synchronous active-low reset
- instr_i  input  12  instruction: [11:9] opcode, [8:6] rd, [5:3] rs, [2:0] rt
- instr_valid_i  input  1  instr_i valid
- instr_ready_o  output  1  stage accepts instr_i this cycle
- rs_o  output  8  operand A to ALU rs_i
- rt_o  output  8  operand B to ALU rt_i
- opcode_o  output  3  to ALU opcode_i
- rd_o  output  3  destination tag travelling with the operation
- wb_req_o  output  1  operation writes rd (opcode not 101/111, rd != 0)
- alu_valid_o  output  1  output register holds an operation
- alu_ready_i  input  1  downstream consumes the operation
- wb_en_i  input  1  writeback strobe
- wb_addr_i  input  3  writeback register
- wb_data_i  input  8  writeback value (ALU result)

Behaviour:
- Single clock clk_i. Reset is synchronous, active-low on rst_n_i. Everything below is sampled at posedge clk_i.
- Reset state:
  - all registers = 0; scoreboard = 0
  - alu_valid_o = 0; rs_o/rt_o/opcode_o/rd_o = 0; wb_req_o = 0
  - instr_ready_o = 0 while rst_n_i low.
- Reset asserted mid-operation discards any held operation and all pending bits.
- out_free = !alu_valid_o || alu_ready_i.
- hazard = instr_valid_i && ((pend[rs] && rs != 0) || (pend[rt] && rt != 0)), after bypass qualification.
- instr_ready_o = out_free && !hazard (combinational).
- Issue: occurs when instr_valid_i && instr_ready_o. On the next edge:
  - operands load from the register file, or from bypass
  - opcode_o/rd_o/wb_req_o load
  - alu_valid_o = 1
  - if wb_req, pend[rd] is set.
  - Issue-to-output latency is 1 cycle.
- No issue while out_free: alu_valid_o clears when alu_ready_i is high. Otherwise all outputs hold stable.
- Compare opcodes 101 and 111 produce only the zero flag: wb_req = 0, no pend set. Writes to rd = 0 also produce wb_req = 0.
- Writeback: wb_en_i && wb_addr_i != 0 writes regs[wb_addr_i] and clears pend[wb_addr_i]. Writeback to r0 is ignored.
- Same-cycle issue and writeback to the same rd: the set from the issuing instruction wins, so pend stays 1.
- Reads of r0 return 0 and never stall.
- State view (per pending bit): IDLE, then PENDING on issue with wb_req, then IDLE on matching wb_en_i. The output register has two states: EMPTY and FULL.

Optional Feature:
- Macro: OPERAND_BYPASS_EN.
- Defined: when wb_en_i matches rs or rt (non-zero) in the issue cycle, that source is not a hazard and the operand is taken from wb_data_i. A dependent instruction issues in the same cycle as the writeback.
- Undefined: a pending source always stalls. The register file is read after the write lands, so issue happens one cycle after the writeback.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then write r1=0x55 and r2=0xAA via wb; issue opcode 000, rd3, rs1, rt2 with alu_ready_i=1 -> next cycle alu_valid_o=1, rs_o=0x55, rt_o=0xAA, opcode_o=000, rd_o=3, wb_req_o=1, pend[3]=1.
- Issue rd3 then a reader of r3; return wb r3=0x0F two cycles later -> instr_ready_o=0 until wb. With OPERAND_BYPASS_EN: issue in the wb cycle, rs_o=0x0F next cycle. Without: issue one cycle later, same value.
- Hold alu_ready_i=0 with alu_valid_o=1 and present a new instruction -> instr_ready_o=0, outputs stable for 3 cycles; raise alu_ready_i -> new operation loads on that edge.
- Issue opcode 101 rd4, rs1, rt1 -> wb_req_o=0, pend[4] stays 0. A following reader of r4 issues without stall.
- wb r0=0xFF, then read rs=0 -> rs_o=0x00, no stall. Issue with rd=0 -> wb_req_o=0.
- Assert rst_n_i low for one cycle while alu_valid_o=1 and pend[3]=1 -> next cycle alu_valid_o=0, all pend=0, registers read 0.

Source files
------------

// File: rtl/operand_issue_stage.sv
// operand_issue_stage
// Holds the 8x8-bit architectural register file, decodes 12-bit instructions,
// and issues rs/rt operands to the ALU through a registered valid/ready stage.
// A per-register pending scoreboard stalls issue on read-after-write hazards.
//
// Optional build macro: OPERAND_BYPASS_EN
//   defined   - a writeback arriving in the issue cycle resolves the hazard and
//               its data is forwarded straight into the operand register.
//   undefined - a pending source always stalls until the write has landed.
module operand_issue_stage #(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [11:0]       instr_i,
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    output logic [DATA_W-1:0] rs_o,
    output logic [DATA_W-1:0] rt_o,
    output logic [2:0]        opcode_o,
    output logic [2:0]        rd_o,
    output logic              wb_req_o,
    output logic              alu_valid_o,
    input  logic              alu_ready_i,
    input  logic              wb_en_i,
    input  logic [2:0]        wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i
);

    localparam logic [2:0] OP_CMP_A = 3'b101;
    localparam logic [2:0] OP_CMP_B = 3'b111;

    typedef struct packed {
        logic [2:0] opcode;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [2:0] rt;
    } instr_t;

    instr_t             instr;
    logic [DATA_W-1:0]  regs [NUM_REGS];
    logic [NUM_REGS-1:0] pend;

    logic              out_free;
    logic              wb_live;
    logic              byp_rs;
    logic              byp_rt;
    logic              haz_rs;
    logic              haz_rt;
    logic              hazard;
    logic              issue;
    logic              wb_req;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;

    assign instr   = instr_t'(instr_i);
    assign wb_live = wb_en_i && (wb_addr_i != 3'd0);

    // Decode, hazard detection, bypass selection and handshake.
    always_comb begin
        out_free = !alu_valid_o || alu_ready_i;
`ifdef OPERAND_BYPASS_EN
        byp_rs = wb_live && (wb_addr_i == instr.rs);
        byp_rt = wb_live && (wb_addr_i == instr.rt);
`else
        byp_rs = 1'b0;
        byp_rt = 1'b0;
`endif
        haz_rs = pend[instr.rs] && (instr.rs != 3'd0) && !byp_rs;
        haz_rt = pend[instr.rt] && (instr.rt != 3'd0) && !byp_rt;
        hazard = instr_valid_i && (haz_rs || haz_rt);
        instr_ready_o = rst_n_i && out_free && !hazard;
        issue = instr_valid_i && instr_ready_o;
        wb_req = (instr.opcode != OP_CMP_A) && (instr.opcode != OP_CMP_B) &&
                 (instr.rd != 3'd0);

        if (instr.rs == 3'd0) begin
            rs_val = '0;
        end else if (byp_rs) begin
            rs_val = wb_data_i;
        end else begin
            rs_val = regs[instr.rs];
        end

        if (instr.rt == 3'd0) begin
            rt_val = '0;
        end else if (byp_rt) begin
            rt_val = wb_data_i;
        end else begin
            rt_val = regs[instr.rt];
        end
    end

    // Register file: writeback port, r0 is never written.
    always_ff @(posedge clk_i) begin
        // NOTE: the register file is reset because reads after reset must return zero.
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_live) begin
            regs[wb_addr_i] <= wb_data_i;
        end
    end

    // Pending scoreboard: writeback clears, issue with wb_req sets.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pend <= '0;
        end else begin
            // NOTE: the set comes after the clear so a same-cycle issue to the same rd keeps pend high.
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wb_live && (wb_addr_i == 3'(i))) begin
                    pend[i] <= 1'b0;
                end
                if (issue && wb_req && (instr.rd == 3'(i))) begin
                    pend[i] <= 1'b1;
                end
            end
        end
    end

    // Output register (EMPTY/FULL): load on issue, drain on alu_ready_i, else hold.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            alu_valid_o <= 1'b0;
            rs_o        <= '0;
            rt_o        <= '0;
            opcode_o    <= 3'd0;
            rd_o        <= 3'd0;
            wb_req_o    <= 1'b0;
        end else if (issue) begin
            alu_valid_o <= 1'b1;
            rs_o        <= rs_val;
            rt_o        <= rt_val;
            opcode_o    <= instr.opcode;
            rd_o        <= instr.rd;
            wb_req_o    <= wb_req;
        end else if (alu_ready_i) begin
            alu_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_issue_stage.sv
// Directed self-checking bench for operand_issue_stage.
// Inputs change 1 time unit after posedge; outputs are sampled there too.
module tb_operand_issue_stage;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [11:0] instr_i;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [7:0]  rs_o;
    logic [7:0]  rt_o;
    logic [2:0]  opcode_o;
    logic [2:0]  rd_o;
    logic        wb_req_o;
    logic        alu_valid_o;
    logic        alu_ready_i;
    logic        wb_en_i;
    logic [2:0]  wb_addr_i;
    logic [7:0]  wb_data_i;

    int total = 0;
    int bad   = 0;

    operand_issue_stage dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .instr_i       (instr_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .rs_o          (rs_o),
        .rt_o          (rt_o),
        .opcode_o      (opcode_o),
        .rd_o          (rd_o),
        .wb_req_o      (wb_req_o),
        .alu_valid_o   (alu_valid_o),
        .alu_ready_i   (alu_ready_i),
        .wb_en_i       (wb_en_i),
        .wb_addr_i     (wb_addr_i),
        .wb_data_i     (wb_data_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [11:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, rt};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic wb_write(input logic [2:0] addr, input logic [7:0] data);
        wb_en_i   = 1'b1;
        wb_addr_i = addr;
        wb_data_i = data;
        tick();
        wb_en_i   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_i       = 1'b0;
        instr_i       = mk(3'd0, 3'd1, 3'd0, 3'd0);
        instr_valid_i = 1'b1;
        alu_ready_i   = 1'b1;
        wb_en_i       = 1'b0;
        wb_addr_i     = 3'd0;
        wb_data_i     = 8'h00;
        tick();
        tick();
        chk1("reset_valid", alu_valid_o, 1'b0);
        chk8("reset_rs", rs_o, 8'h00);
        chk8("reset_rt", rt_o, 8'h00);
        chk8("reset_op_rd", {2'b00, opcode_o, rd_o}, 8'h00);
        chk1("reset_wbreq", wb_req_o, 1'b0);
        chk1("reset_ready_low", instr_ready_o, 1'b0);
        instr_valid_i = 1'b0;
        rst_n_i       = 1'b1;
        tick();
        chk1("ready_after_reset", instr_ready_o, 1'b1);
    endtask

    task automatic test_basic_issue();
        wb_write(3'd1, 8'h55);
        wb_write(3'd2, 8'hAA);
        instr_i       = mk(3'b000, 3'd3, 3'd1, 3'd2);
        instr_valid_i = 1'b1;
        #1;
        chk1("basic_ready", instr_ready_o, 1'b1);
        tick();
        instr_valid_i = 1'b0;
        chk1("basic_valid", alu_valid_o, 1'b1);
        chk8("basic_rs", rs_o, 8'h55);
        chk8("basic_rt", rt_o, 8'hAA);
        chk8("basic_opcode", {5'd0, opcode_o}, 8'h00);
        chk8("basic_rd", {5'd0, rd_o}, 8'h03);
        chk1("basic_wbreq", wb_req_o, 1'b1);
        tick();
        chk1("basic_drained", alu_valid_o, 1'b0);
    endtask

    // r3 is pending from test_basic_issue; a reader of r3 must wait for its writeback.
    task automatic test_raw_hazard();
        instr_i       = mk(3'b000, 3'd5, 3'd3, 3'd0);
        instr_valid_i = 1'b1;
        #1;
        chk1("raw_stall0", instr_ready_o, 1'b0);
        tick();
        chk1("raw_stall1", instr_ready_o, 1'b0);
        wb_en_i   = 1'b1;
        wb_addr_i = 3'd3;
        wb_data_i = 8'h0F;
        #1;
`ifdef OPERAND_BYPASS_EN
        chk1("raw_ready_in_wb_cycle", instr_ready_o, 1'b1);
        tick();
        wb_en_i       = 1'b0;
        instr_valid_i = 1'b0;
        chk1("raw_issued_valid", alu_valid_o, 1'b1);
        chk8("raw_bypass_rs", rs_o, 8'h0F);
`else
        chk1("raw_stall_in_wb_cycle", instr_ready_o, 1'b0);
        tick();
        wb_en_i = 1'b0;
        chk1("raw_not_issued", alu_valid_o, 1'b0);
        chk1("raw_ready_after_wb", instr_ready_o, 1'b1);
        tick();
        instr_valid_i = 1'b0;
        chk1("raw_issued_valid", alu_valid_o, 1'b1);
        chk8("raw_rs", rs_o, 8'h0F);
`endif
        chk8("raw_rd", {5'd0, rd_o}, 8'h05);
        tick();
    endtask

    task automatic test_back_pressure();
        alu_ready_i   = 1'b0;
        instr_i       = mk(3'b000, 3'd6, 3'd1, 3'd2);
        instr_valid_i = 1'b1;
        tick();
        chk1("bp_first_valid", alu_valid_o, 1'b1);
        instr_i = mk(3'b001, 3'd7, 3'd2, 3'd1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("bp_ready_low", instr_ready_o, 1'b0);
            tick();
            chk1("bp_valid_hold", alu_valid_o, 1'b1);
            chk8("bp_rs_hold", rs_o, 8'h55);
            chk8("bp_rt_hold", rt_o, 8'hAA);
            chk8("bp_oprd_hold", {2'b00, opcode_o, rd_o}, {2'b00, 3'b000, 3'd6});
        end
        alu_ready_i = 1'b1;
        #1;
        chk1("bp_ready_release", instr_ready_o, 1'b1);
        tick();
        instr_valid_i = 1'b0;
        chk8("bp_new_rs", rs_o, 8'hAA);
        chk8("bp_new_rt", rt_o, 8'h55);
        chk8("bp_new_oprd", {2'b00, opcode_o, rd_o}, {2'b00, 3'b001, 3'd7});
        chk1("bp_new_wbreq", wb_req_o, 1'b1);
        tick();
        chk1("bp_drained", alu_valid_o, 1'b0);
    endtask

    task automatic test_compare_and_rd0();
        instr_i       = mk(3'b101, 3'd4, 3'd1, 3'd1);
        instr_valid_i = 1'b1;
        tick();
        chk1("cmp101_wbreq", wb_req_o, 1'b0);
        chk8("cmp101_rs", rs_o, 8'h55);
        chk8("cmp101_oprd", {2'b00, opcode_o, rd_o}, {2'b00, 3'b101, 3'd4});
        // r4 is not pending: reader issues immediately; rd=0 gives no wb_req.
        instr_i = mk(3'b000, 3'd0, 3'd4, 3'd2);
        #1;
        chk1("cmp_reader_nostall", instr_ready_o, 1'b1);
        tick();
        chk1("rd0_valid", alu_valid_o, 1'b1);
        chk8("rd0_rs_r4", rs_o, 8'h00);
        chk8("rd0_rt_r2", rt_o, 8'hAA);
        chk1("rd0_wbreq", wb_req_o, 1'b0);
        instr_i = mk(3'b111, 3'd4, 3'd2, 3'd2);
        tick();
        chk1("cmp111_wbreq", wb_req_o, 1'b0);
        instr_i = mk(3'b000, 3'd0, 3'd4, 3'd4);
        #1;
        chk1("cmp111_nostall", instr_ready_o, 1'b1);
        instr_valid_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_r0();
        wb_write(3'd0, 8'hFF);
        instr_i       = mk(3'b010, 3'd0, 3'd0, 3'd1);
        instr_valid_i = 1'b1;
        #1;
        chk1("r0_nostall", instr_ready_o, 1'b1);
        tick();
        instr_valid_i = 1'b0;
        chk8("r0_reads_zero", rs_o, 8'h00);
        chk8("r0_rt_r1", rt_o, 8'h55);
        tick();
    endtask

    task automatic test_reset_mid();
        alu_ready_i   = 1'b0;
        instr_i       = mk(3'b000, 3'd3, 3'd1, 3'd2);
        instr_valid_i = 1'b1;
        tick();
        instr_valid_i = 1'b0;
        chk1("mid_valid_before", alu_valid_o, 1'b1);
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        chk1("mid_valid_cleared", alu_valid_o, 1'b0);
        alu_ready_i   = 1'b1;
        instr_i       = mk(3'b000, 3'd0, 3'd3, 3'd1);
        instr_valid_i = 1'b1;
        #1;
        chk1("mid_pend_cleared", instr_ready_o, 1'b1);
        tick();
        instr_valid_i = 1'b0;
        chk1("mid_reader_valid", alu_valid_o, 1'b1);
        chk8("mid_r3_zero", rs_o, 8'h00);
        chk8("mid_r1_zero", rt_o, 8'h00);
    endtask

    initial begin
        test_reset();
        test_basic_issue();
        test_raw_hazard();
        test_back_pressure();
        test_compare_and_rd0();
        test_r0();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard bound so the run always terminates.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
